// File: rtl/lbp_pkg.sv
// Shared constants and types for the LBP histogram block.
//   IMG_W   : frame width/height in pixels (power of two)
//   ADDR_W  : pixel address width (row*IMG_W + col)
//   COUNT_W : per-bin counter width, must hold IMG_W*IMG_W
//   NBINS   : number of histogram bins (one per 8-bit LBP code)
package lbp_pkg;

    localparam int unsigned IMG_W   = 128;
    localparam int unsigned ADDR_W  = 14;
    localparam int unsigned COUNT_W = 15;
    localparam int unsigned NBINS   = 256;
    localparam int unsigned COL_W   = $clog2(IMG_W);

    typedef enum logic [1:0] {
        StClear,
        StAccum,
        StDrain,
        StDone
    } state_e;

    typedef logic [7:0]         lbp_code_t;
    typedef logic [COUNT_W-1:0] count_t;
    typedef logic [COUNT_W:0]   total_t;

endpackage

// File: rtl/lbp_hist_bank.sv
// Bin storage: NBINS x COUNT_W register array.
//   clk_i              : clock
//   clr_en_i/clr_idx_i : zero one bin per cycle (has priority over increment)
//   inc_en_i/inc_idx_i : saturating +1 of one bin, single-cycle read-modify-write
//   rd_idx_i           : combinational read index
//   rd_count_o         : count of bin rd_idx_i
// Contents are not reset; the owner clears them before use.
module lbp_hist_bank
    import lbp_pkg::*;
(
    input  logic      clk_i,
    input  logic      clr_en_i,
    input  lbp_code_t clr_idx_i,
    input  logic      inc_en_i,
    input  lbp_code_t inc_idx_i,
    input  lbp_code_t rd_idx_i,
    output count_t    rd_count_o
);

    count_t bins_q [NBINS];

    always_ff @(posedge clk_i) begin
        if (clr_en_i) begin
            bins_q[clr_idx_i] <= '0;
        end else if (inc_en_i && (bins_q[inc_idx_i] != '1)) begin
            bins_q[inc_idx_i] <= bins_q[inc_idx_i] + count_t'(1);
        end
    end

    assign rd_count_o = bins_q[rd_idx_i];

endmodule

// File: rtl/lbp_hist.sv
// LBP code histogram: snoops the LBP write port, accumulates a 256-bin histogram
// for one frame, then streams the bins out over valid/ready.
//   clk_i, reset_ni        : clock, asynchronous active-low reset
//   lbp_valid_i/addr/data  : upstream pixel strobe, pixel address, LBP code
//   finish_i               : upstream frame-complete level
//   start_i                : pulse in DONE restarts a new frame
//   hist_valid_o/ready_i   : bin stream handshake
//   hist_bin_o/count_o     : bin index and its count
//   hist_total_o           : pixels accumulated this frame
//   hist_done_o            : all bins drained
//   drop_err_o             : sticky, a pixel arrived outside accumulation
// Build option: define LBP_HIST_BORDER_SKIP_EN to ignore frame-border pixels.
module lbp_hist
    import lbp_pkg::*;
(
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              lbp_valid_i,
    input  logic [ADDR_W-1:0] lbp_addr_i,
    input  lbp_code_t         lbp_data_i,
    input  logic              finish_i,
    input  logic              start_i,
    output logic              hist_valid_o,
    input  logic              hist_ready_i,
    output lbp_code_t         hist_bin_o,
    output count_t            hist_count_o,
    output total_t            hist_total_o,
    output logic              hist_done_o,
    output logic              drop_err_o
);

    state_e    state_q, state_d;
    lbp_code_t idx_q, idx_d;     // clear index in StClear, drain index in StDrain
    logic      vld_q, vld_d;
    lbp_code_t code_q, code_d;
    total_t    total_q, total_d;
    logic      drop_q, drop_d;
    logic      pix_skip, take, xfer;
    count_t    rd_count;

`ifdef LBP_HIST_BORDER_SKIP_EN
    logic [COL_W-1:0] row, col;
    assign row      = lbp_addr_i[ADDR_W-1:COL_W];
    assign col      = lbp_addr_i[COL_W-1:0];
    assign pix_skip = (row == '0) || (row == '1) || (col == '0) || (col == '1);
`else
    logic unused_addr;
    assign unused_addr = ^lbp_addr_i;
    assign pix_skip    = 1'b0;
`endif

    assign take = lbp_valid_i && !pix_skip && (state_q == StAccum);
    assign xfer = hist_valid_o && hist_ready_i;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        vld_d   = take;
        code_d  = take ? lbp_data_i : code_q;
        total_d = total_q;
        drop_d  = drop_q | (lbp_valid_i && !pix_skip && (state_q != StAccum));

        // vld_q is only ever set in StAccum and must be clear to leave it.
        if (vld_q && (total_q != '1)) begin
            total_d = total_q + total_t'(1);
        end

        unique case (state_q)
            StClear: begin
                idx_d = idx_q + 8'd1;
                if (idx_q == '1) begin
                    state_d = StAccum;
                    total_d = '0;
                end
            end
            StAccum: begin
                // Leave only once the input stage is drained and nothing new arrives.
                if (finish_i && !vld_q && !take) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (xfer) begin
                    idx_d = idx_q + 8'd1;
                    if (idx_q == '1) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (start_i) begin
                    state_d = StClear;
                    idx_d   = '0;
                    drop_d  = 1'b0;
                end
            end
            default: state_d = StClear;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= StClear;
            idx_q   <= '0;
            vld_q   <= 1'b0;
            code_q  <= '0;
            total_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
            code_q  <= code_d;
            total_q <= total_d;
            drop_q  <= drop_d;
        end
    end

    lbp_hist_bank u_bank (
        .clk_i      (clk_i),
        .clr_en_i   (state_q == StClear),
        .clr_idx_i  (idx_q),
        .inc_en_i   (vld_q),
        .inc_idx_i  (code_q),
        .rd_idx_i   (idx_q),
        .rd_count_o (rd_count)
    );

    // Bin outputs are forced to zero outside DRAIN so reset shows all-zero outputs.
    assign hist_valid_o = (state_q == StDrain);
    assign hist_bin_o   = hist_valid_o ? idx_q : '0;
    assign hist_count_o = hist_valid_o ? rd_count : '0;
    assign hist_total_o = total_q;
    assign hist_done_o  = (state_q == StDone);
    assign drop_err_o   = drop_q;

endmodule

// File: tb/tb_lbp_hist.sv
module tb_lbp_hist;
    import lbp_pkg::*;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              lbp_valid;
    logic [ADDR_W-1:0] lbp_addr;
    lbp_code_t         lbp_data;
    logic              finish;
    logic              start;
    logic              hist_valid;
    logic              hist_ready;
    lbp_code_t         hist_bin;
    count_t            hist_count;
    total_t            hist_total;
    logic              hist_done;
    logic              drop_err;

    int n_cmp = 0;
    int n_bad = 0;

    count_t exp_bins [NBINS];

    typedef struct {
        logic [ADDR_W-1:0] addr;
        int unsigned       stride;
        lbp_code_t         code;
        int unsigned       n;
        int unsigned       exp_cnt;
        int unsigned       exp_total;
        bit                stall;
    } vec_t;

    vec_t vecs [6];

`ifdef LBP_HIST_BORDER_SKIP_EN
    localparam bit Skip = 1'b1;
`else
    localparam bit Skip = 1'b0;
`endif

    always #5 clk = ~clk;

    lbp_hist dut (
        .clk_i        (clk),
        .reset_ni     (reset_n),
        .lbp_valid_i  (lbp_valid),
        .lbp_addr_i   (lbp_addr),
        .lbp_data_i   (lbp_data),
        .finish_i     (finish),
        .start_i      (start),
        .hist_valid_o (hist_valid),
        .hist_ready_i (hist_ready),
        .hist_bin_o   (hist_bin),
        .hist_count_o (hist_count),
        .hist_total_o (hist_total),
        .hist_done_o  (hist_done),
        .drop_err_o   (drop_err)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, hist_valid, 0);
        chk({tag, "_bin"},   hist_bin,   0);
        chk({tag, "_count"}, hist_count, 0);
        chk({tag, "_total"}, hist_total, 0);
        chk({tag, "_done"},  hist_done,  0);
        chk({tag, "_drop"},  drop_err,   0);
    endtask

    task automatic set_exp(input lbp_code_t code, input int unsigned cnt);
        for (int i = 0; i < NBINS; i++) exp_bins[i] = '0;
        exp_bins[code] = count_t'(cnt);
    endtask

    // Walks the 256 clear cycles; optionally pokes a pixel at clear cycle drop_at.
    task automatic wait_clear(input int drop_at);
        for (int i = 0; i < NBINS; i++) begin
            if (i == drop_at) begin
                lbp_valid = 1'b1;
                lbp_addr  = 14'd200;
                lbp_data  = 8'd9;
            end
            @(negedge clk);
            lbp_valid = 1'b0;
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Pixels back-to-back; finish rises with the last valid so it must still count.
    task automatic feed(input vec_t v);
        for (int unsigned i = 0; i < v.n; i++) begin
            lbp_valid = 1'b1;
            lbp_addr  = v.addr + ADDR_W'(i * v.stride);
            lbp_data  = v.code;
            start     = (i == 0);      // start outside DONE must be ignored
            finish    = (i == v.n - 1);
            @(negedge clk);
        end
        lbp_valid = 1'b0;
        start     = 1'b0;
        finish    = 1'b1;
    endtask

    task automatic drain(input bit stall, input int stop_at, input longint exp_total);
        int        beats   = 0;
        int        cyc     = 0;
        int        stall17 = 0;
        bit        held    = 1'b0;
        bit        rdy;
        lbp_code_t hb      = '0;
        count_t    hc      = '0;
        while (beats < NBINS && cyc < 4000) begin
            if (hist_valid) begin
                if (held) begin
                    chk("stall_bin_hold", hist_bin, hb);
                    chk("stall_count_hold", hist_count, hc);
                end
                chk("drain_bin", hist_bin, beats);
                chk("drain_count", hist_count, exp_bins[beats]);
                if (beats == stop_at) begin
                    hist_ready = 1'b0;
                    return;
                end
                rdy = 1'b1;
                if (stall) begin
                    if (beats == 17 && stall17 < 3) begin
                        rdy = 1'b0;
                        stall17++;
                    end else if ($urandom_range(0, 3) == 0) begin
                        rdy = 1'b0;
                    end
                end
                hist_ready = rdy;
                held       = !rdy;
                hb         = hist_bin;
                hc         = hist_count;
                if (rdy) beats++;
            end else begin
                hist_ready = 1'(stall ? $urandom_range(0, 1) : 1);
            end
            @(negedge clk);
            cyc++;
        end
        hist_ready = 1'b0;
        chk("handshakes", beats, NBINS);
        chk("valid_after_last", hist_valid, 0);
        chk("done_after_last", hist_done, 1);
        chk("total", hist_total, exp_total);
    endtask

    initial begin
        reset_n    = 1'b0;
        lbp_valid  = 1'b0;
        lbp_addr   = '0;
        lbp_data   = '0;
        finish     = 1'b0;
        start      = 1'b0;
        hist_ready = 1'b0;

        vecs[0] = '{addr: 14'd129,   stride: 1, code: 8'd5,   n: 3,
                    exp_cnt: 3, exp_total: 3, stall: 1'b1};
        vecs[1] = '{addr: 14'd0,     stride: 1, code: 8'd0,   n: 2,
                    exp_cnt: Skip ? 0 : 2, exp_total: Skip ? 0 : 2, stall: 1'b0};
        vecs[2] = '{addr: 14'd254,   stride: 1, code: 8'hA5,  n: 3,
                    exp_cnt: Skip ? 1 : 3, exp_total: Skip ? 1 : 3, stall: 1'b0};
        vecs[3] = '{addr: 14'd16383, stride: 1, code: 8'd7,   n: 1,
                    exp_cnt: Skip ? 0 : 1, exp_total: Skip ? 0 : 1, stall: 1'b0};
        vecs[4] = '{addr: 14'd0,     stride: 1, code: 8'hFF,  n: 16384,
                    exp_cnt: Skip ? 15876 : 16384, exp_total: Skip ? 15876 : 16384,
                    stall: 1'b0};
        vecs[5] = '{addr: 14'd129,   stride: 0, code: 8'd3,   n: 32770,
                    exp_cnt: 32767, exp_total: 32770, stall: 1'b1};

        #23;
        chk_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;
        wait_clear(-1);
        chk("total_after_clear", hist_total, 0);

        // Empty frame: all bins zero straight after reset.
        finish = 1'b1;
        set_exp(8'd0, 0);
        drain(1'b0, -1, 0);
        chk("drop_idle", drop_err, 0);
        finish = 1'b0;

        // Pixel during CLEAR is dropped and flagged; bins stay zero.
        do_start();
        wait_clear(10);
        chk("drop_err_set", drop_err, 1);
        finish = 1'b1;
        drain(1'b0, -1, 0);
        chk("drop_err_held", drop_err, 1);
        finish = 1'b0;
        do_start();
        chk("drop_err_cleared", drop_err, 0);
        chk("done_cleared", hist_done, 0);
        wait_clear(-1);

        for (int k = 0; k < 6; k++) begin
            feed(vecs[k]);
            set_exp(vecs[k].code, vecs[k].exp_cnt);
            drain(vecs[k].stall, -1, vecs[k].exp_total);
            chk("drop_none", drop_err, 0);
            finish = 1'b0;
            do_start();
            wait_clear(-1);
        end

        // Reset in the middle of draining: outputs clear at once, next frame is clean.
        feed(vecs[0]);
        set_exp(vecs[0].code, vecs[0].exp_cnt);
        drain(1'b0, 100, 0);
        chk("pre_reset_valid", hist_valid, 1);
        reset_n = 1'b0;
        finish  = 1'b0;
        #1;
        chk_zero("mid_reset");
        @(negedge clk);
        reset_n = 1'b1;
        wait_clear(-1);
        finish = 1'b1;
        set_exp(8'd0, 0);
        drain(1'b0, -1, 0);
        finish = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lbp_hist.md
Name: lbp_hist

Overview:
- Downstream consumer of the LBP stage. Snoops the LBP write port (lbp_valid/lbp_addr/lbp_data) and builds a 256-bin histogram of LBP codes for one 128x128 frame.
- On upstream finish, streams the bins out over a valid/ready interface for the feature/matching stage.
- Bin storage is an internal register array. No external memory.

Parameters:
- IMG_W, 128, image width in pixels (power of two); lbp_addr = row*IMG_W + col.
- ADDR_W, 14, pixel address width.
- COUNT_W, 15, bin counter width; must hold IMG_W*IMG_W = 16384.
- NBINS, 256, number of bins (fixed by 8-bit LBP code).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- lbp_valid  in  1  upstream LBP result strobe, one pixel per asserted cycle.
- lbp_addr  in  ADDR_W  pixel address of lbp_data.
- lbp_data  in  8  LBP code, used as the bin index.
- finish  in  1  upstream frame-complete level; sampled, not edge-required.
- start  in  1  one-cycle pulse; restarts a new frame from DONE.
- hist_valid  out  1  bin output valid.
- hist_ready  in  1  downstream accepts the bin.
- hist_bin  out  8  bin index being presented.
- hist_count  out  COUNT_W  count for hist_bin.
- hist_total  out  COUNT_W+1  number of pixels accumulated this frame.
- hist_done  out  1  high after bin 255 has been accepted.
- drop_err  out  1  sticky; a valid arrived outside ACCUM.

Behaviour:
- Reset (async assert, sync release): state = CLEAR, clear index = 0, all outputs 0, bins undefined until CLEAR completes.
- CLEAR: writes one bin to 0 per cycle, for indices 0..255, taking 256 cycles. Then goes to ACCUM with hist_total = 0.
- ACCUM:
  - Input register stage: (lbp_valid, lbp_data) is captured at cycle N.
  - At cycle N+1, bin[code] <= bin[code] + 1 and hist_total += 1. This is a single-cycle read-modify-write on the register array, so back-to-back identical codes must each count.
  - Bins saturate at 2^COUNT_W - 1. They do not wrap.
- ACCUM -> DRAIN: when finish = 1 and the input stage is empty (no update pending). A valid in the same cycle as finish is still counted.
- DRAIN:
  - hist_valid = 1, hist_bin = idx, hist_count = bin[idx], with idx starting at 0.
  - The transfer completes when hist_valid & hist_ready; idx then increments on the next edge.
  - While hist_valid & !hist_ready, hist_bin and hist_count are held stable.
  - When idx = 255 is accepted, hist_valid drops on the next cycle and the block goes to DONE.
- DONE: hist_done = 1. hist_total and the bins are held. start = 1 causes hist_done = 0, drop_err = 0, and a return to CLEAR. start in any other state is ignored.
- lbp_valid in CLEAR, DRAIN or DONE: the pixel is dropped and drop_err is set (sticky until start or reset).
- Reset mid-operation (any state): returns immediately to CLEAR. A partial histogram is never drained.
- hist_total counts accepted pixels, including border pixels when BORDER_SKIP_EN is off; it does not saturate below 2^(COUNT_W+1) - 1.

Optional Feature:
- Macro LBP_HIST_BORDER_SKIP_EN.
- Defined: a pixel is ignored (no bin update, no hist_total increment, no drop_err) when row = lbp_addr / IMG_W or col = lbp_addr % IMG_W is 0 or IMG_W-1. This excludes border pixels whose neighbourhood is not valid. A full frame then gives hist_total = 126*126 = 15876.
- Undefined: every pixel counts, and a full frame gives hist_total = 16384.

Decomposition:
- Package lbp_pkg holds:
  - IMG_W, ADDR_W and COUNT_W constants.
  - The state enum {CLEAR, ACCUM, DRAIN, DONE}.
  - The lbp_code_t (8-bit) typedef.
  - The count_t typedef.
- Sub-module lbp_hist_bank: 256 x COUNT_W register array with a clear port, a saturating increment port and a read port. The FSM, input stage and handshake remain in lbp_hist.

Test Plan:
- After reset release, wait 256 cycles. Then drain with hist_ready = 1 -> 256 beats, all hist_count = 0, hist_bin 0..255 in order, hist_done = 1 one cycle after the last beat.
- Feed 16384 interior-and-border pixels all with code 8'hFF, back-to-back, then finish:
  - Feature off -> bin 255 = 16384, all other bins 0, hist_total = 16384.
  - Feature on -> bin 255 = 15876.
- Feed addr 129,130,131 with codes 5,5,5 on consecutive cycles, then finish -> bin 5 = 3, hist_total = 3 (RMW back-to-back check).
- During DRAIN, toggle hist_ready randomly (e.g. low for 3 cycles at bin 17) -> hist_bin/hist_count are held stable while stalled, no bin is skipped or duplicated, and exactly 256 handshakes occur.
- Assert lbp_valid during CLEAR (cycle 10) -> drop_err = 1, no bin changes. Then start in DONE -> drop_err = 0 and a fresh 256-cycle CLEAR.
- Assert reset_n = 0 mid-DRAIN at bin 100 -> all outputs 0 asynchronously. After release, CLEAR runs and a subsequent drain gives all bins 0.
